// File: rtl/tr_defuzzy_seq.sv
// Sequenced type-reduction / centroid defuzzifier for the interval type-2 fuzzy processor.
// Averages three FOU strength pairs, forms weighted sums, then divides with an 18-step restoring divider.
module tr_defuzzy_seq #(
    parameter logic [7:0] POS1    = 8'd0,
    parameter logic [7:0] POS2    = 8'd128,
    parameter logic [7:0] POS3    = 8'd255,
    parameter logic [7:0] DEFAULT = 8'd128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] FOU_1_UP,
    input  logic [7:0] FOU_2_UP,
    input  logic [7:0] FOU_3_UP,
    input  logic [7:0] FOU_1_LOW,
    input  logic [7:0] FOU_2_LOW,
    input  logic [7:0] FOU_3_LOW,
    output logic [7:0] saida,
    output logic       busy,
    output logic       done,
    output logic       div_zero
);

    localparam int unsigned NUM_W = 18;
    localparam int unsigned DEN_W = 10;
    localparam int unsigned CNT_W = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUM  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(NUM_W - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic [7:0]       r_up1, r_up2, r_up3;
    logic [7:0]       r_low1, r_low2, r_low3;
    logic [NUM_W-1:0] r_num;
    logic [DEN_W-1:0] r_den;
    logic [DEN_W-1:0] r_rem;
    logic [NUM_W-1:0] r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_zero;
    logic [7:0]       r_saida;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    logic [7:0]       w_f1, w_f2, w_f3;
    logic [NUM_W-1:0] w_num;
    logic [DEN_W-1:0] w_den;
    logic [DEN_W:0]   w_rem_sh;
    logic [DEN_W:0]   w_rem_nxt;
    logic             w_ge;

    // Averaged FOU strengths and the weighted sums taken in SUM
    always_comb begin
        w_f1  = 8'((9'(r_up1) + 9'(r_low1)) >> 1);
        w_f2  = 8'((9'(r_up2) + 9'(r_low2)) >> 1);
        w_f3  = 8'((9'(r_up3) + 9'(r_low3)) >> 1);
        w_num = NUM_W'(w_f1) * NUM_W'(POS1)
              + NUM_W'(w_f2) * NUM_W'(POS2)
              + NUM_W'(w_f3) * NUM_W'(POS3);
        w_den = DEN_W'(w_f1) + DEN_W'(w_f2) + DEN_W'(w_f3);
    end

    // One restoring-division step; the stored remainder is always below den, so 10 bits hold it
    always_comb begin
        w_rem_sh  = {r_rem, r_num[NUM_W-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_den});
        w_rem_nxt = w_ge ? (w_rem_sh - {1'b0, r_den}) : w_rem_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SUM;
            S_SUM:   w_state_nxt = (w_den == '0) ? S_FIN : S_DIV;
            S_DIV:   if (r_cnt == '0) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, divider datapath and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up1      <= '0;
            r_up2      <= '0;
            r_up3      <= '0;
            r_low1     <= '0;
            r_low2     <= '0;
            r_low3     <= '0;
            r_num      <= '0;
            r_den      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_zero     <= 1'b0;
            r_saida    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_up1  <= FOU_1_UP;
                        r_up2  <= FOU_2_UP;
                        r_up3  <= FOU_3_UP;
                        r_low1 <= FOU_1_LOW;
                        r_low2 <= FOU_2_LOW;
                        r_low3 <= FOU_3_LOW;
                        r_busy <= 1'b1;
                    end
                end
                S_SUM: begin
                    r_num  <= w_num;
                    r_den  <= w_den;
                    r_zero <= (w_den == '0);
                    r_cnt  <= DIV_LAST;
                    r_rem  <= '0;
                    r_quo  <= '0;
                end
                S_DIV: begin
                    r_num <= {r_num[NUM_W-2:0], 1'b0};
                    r_rem <= DEN_W'(w_rem_nxt);
                    r_quo <= {r_quo[NUM_W-2:0], w_ge};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIN: begin
                    if (r_zero) begin
                        r_saida    <= DEFAULT;
                        r_div_zero <= 1'b1;
                    end else begin
                        r_saida    <= (|r_quo[NUM_W-1:8]) ? 8'hFF : r_quo[7:0];
                        r_div_zero <= 1'b0;
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign saida    = r_saida;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_tr_defuzzy_seq.sv
// Directed bench for tr_defuzzy_seq: centroid values, latency, zero denominator,
// dropped starts, mid-operation reset and back-to-back operation.
module tb_tr_defuzzy_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] u1, u2, u3, l1, l2, l3;
    logic [7:0] saida;
    logic       busy;
    logic       done;
    logic       div_zero;

    int checks;
    int failures;

    tr_defuzzy_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .FOU_1_UP  (u1),
        .FOU_2_UP  (u2),
        .FOU_3_UP  (u3),
        .FOU_1_LOW (l1),
        .FOU_2_LOW (l2),
        .FOU_3_LOW (l3),
        .saida     (saida),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_in(input logic [7:0] a1, b1, a2, b2, a3, b3);
        u1 = a1; l1 = b1; u2 = a2; l2 = b2; u3 = a3; l3 = b3;
    endtask

    // Pulse start once, then return #1 after the edge where done rises (lat = edges after accept, -1 on timeout)
    task automatic do_op(input logic [7:0] a1, b1, a2, b2, a3, b3,
                         output int lat, output logic busy1, output logic [7:0] saida1);
        @(posedge clk);
        #1;
        set_in(a1, b1, a2, b2, a3, b3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy1  = busy;
        saida1 = saida;
        lat    = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) begin
                @(posedge clk);
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        set_in(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (saida !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_values saida=%0d busy=%b done=%b dz=%b required 0/0/0/0",
                     saida, busy, done, div_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_all_100();
        int lat; logic b1; logic [7:0] s1;
        do_op(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, lat, b1, s1);
        checks++;
        if (lat !== 20) begin
            failures++;
            $display("FAIL all100_latency got=%0d required=20", lat);
        end
        checks++;
        if (saida !== 8'd127 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL all100_result saida=%0d dz=%b required 127/0", saida, div_zero);
        end
        checks++;
        if (b1 !== 1'b1 || s1 !== 8'd0) begin
            failures++;
            $display("FAIL all100_busy_hold busy=%b saida=%0d required 1/0", b1, s1);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL all100_busy_at_done busy=%b required 0", busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || saida !== 8'd127) begin
            failures++;
            $display("FAIL all100_done_width done=%b saida=%0d required 0/127", done, saida);
        end
    endtask

    task automatic test_single_consequents();
        int lat; logic b1; logic [7:0] s1;
        do_op(8'd0, 8'd0, 8'd60, 8'd40, 8'd0, 8'd0, lat, b1, s1);
        checks++;
        if (lat !== 20 || saida !== 8'd128 || s1 !== 8'd127) begin
            failures++;
            $display("FAIL only_c2 lat=%0d saida=%0d held=%0d required 20/128/127", lat, saida, s1);
        end
        do_op(8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, lat, b1, s1);
        checks++;
        if (lat !== 20 || saida !== 8'd255 || s1 !== 8'd128) begin
            failures++;
            $display("FAIL only_c3 lat=%0d saida=%0d held=%0d required 20/255/128", lat, saida, s1);
        end
        do_op(8'd200, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, lat, b1, s1);
        checks++;
        if (lat !== 20 || saida !== 8'd0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL only_c1 lat=%0d saida=%0d dz=%b required 20/0/0", lat, saida, div_zero);
        end
    endtask

    task automatic test_zero_den();
        int lat; logic b1; logic [7:0] s1;
        do_op(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, lat, b1, s1);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL zero_latency got=%0d required=2", lat);
        end
        checks++;
        if (saida !== 8'd128 || div_zero !== 1'b1) begin
            failures++;
            $display("FAIL zero_result saida=%0d dz=%b required 128/1", saida, div_zero);
        end
        checks++;
        if (b1 !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_busy after_accept=%b at_done=%b required 1/0", b1, busy);
        end
        // div_zero must clear on the next real result
        do_op(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, lat, b1, s1);
        checks++;
        if (saida !== 8'd127 || div_zero !== 1'b0 || s1 !== 8'd128) begin
            failures++;
            $display("FAIL zero_clear saida=%0d dz=%b held=%0d required 127/0/128", saida, div_zero, s1);
        end
    endtask

    task automatic test_ignored_start();
        int dones; int first;
        @(posedge clk);
        #1;
        set_in(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        first = -1;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                if (first < 0) first = n;
            end
            if (n == 5) begin
                set_in(8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255);
                start = 1'b1;
            end else if (n == 6) begin
                start = 1'b0;
            end
            if (n == first) begin
                checks++;
                if (saida !== 8'd127) begin
                    failures++;
                    $display("FAIL ignored_start_result saida=%0d required 127", saida);
                end
            end
        end
        checks++;
        if (dones !== 1 || first !== 20) begin
            failures++;
            $display("FAIL ignored_start_pulses count=%0d first=%0d required 1/20", dones, first);
        end
    endtask

    task automatic test_reset_mid();
        int dones; int lat; logic b1; logic [7:0] s1;
        @(posedge clk);
        #1;
        set_in(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (saida !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async saida=%0d busy=%b done=%b dz=%b required 0/0/0/0",
                     saida, busy, done, div_zero);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_done dones=%0d busy=%b required 0/0", dones, busy);
        end
        do_op(8'd0, 8'd0, 8'd60, 8'd40, 8'd0, 8'd0, lat, b1, s1);
        checks++;
        if (lat !== 20 || saida !== 8'd128 || s1 !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid_restart lat=%0d saida=%0d held=%0d required 20/128/0", lat, saida, s1);
        end
    endtask

    task automatic test_back_to_back();
        int t[2]; int k; int gap;
        @(posedge clk);
        #1;
        set_in(8'd1, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0);
        start = 1'b1;
        k = 0;
        t[0] = -1;
        t[1] = -1;
        for (int n = 0; n < 80 && k < 2; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                t[k] = n;
                k++;
                checks++;
                if (saida !== 8'd255 || div_zero !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_result%0d saida=%0d dz=%b required 255/0", k, saida, div_zero);
                end
            end
        end
        start = 1'b0;
        gap = (k == 2) ? (t[1] - t[0]) : -1;
        checks++;
        if (gap !== 21) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d required=21", gap);
        end
        repeat (30) @(posedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        set_in(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        test_reset();
        test_all_100();
        test_single_consequents();
        test_zero_den();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
